traffic_light_ctrl: RTL

//  Two-way intersection sequencer (north-south / east-west).

---
 rtl/traffic_pkg.sv | 29 ++
 rtl/bin2bcd_2d.sv | 12 +
 rtl/traffic_light_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-way traffic light controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN,
    NS_YELLOW,
    EW_GREEN,
    EW_YELLOW,
    NIGHT_BLINK
  } tlc_state_t;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Day-cycle successor; NIGHT_BLINK falls back to the start of the cycle.
  function automatic tlc_state_t tlc_next(input tlc_state_t s);
    case (s)
      NS_GREEN:  return NS_YELLOW;
      NS_YELLOW: return EW_GREEN;
      EW_GREEN:  return EW_YELLOW;
      default:   return NS_GREEN;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_2d.sv
// Combinational 7-bit binary (0..99) to two-digit BCD {tens, ones}.
module bin2bcd_2d (
  input  logic [6:0] bin,
  output logic [7:0] bcd
);

  always_comb begin
    bcd[7:4] = 4'(bin / 7'd10);
    bcd[3:0] = 4'(bin % 7'd10);
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Four-phase NS/EW intersection sequencer with per-direction BCD countdown.
// Optional blinking-yellow night mode is built only when TLC_NIGHT_MODE_EN is defined.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int TICK_MAX = 49_999_999,
  parameter int GREEN_S  = 25,
  parameter int YELLOW_S = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        night,
  output logic [2:0]  light_ns,
  output logic [2:0]  light_ew,
  output logic [15:0] disp_data,
  output logic        tick_1s
);

  localparam int         PW  = (TICK_MAX < 1) ? 1 : $clog2(TICK_MAX + 1);
  localparam logic [6:0] G7  = 7'(GREEN_S);
  localparam logic [6:0] Y7  = 7'(YELLOW_S);

  logic [PW-1:0]   presc;
  logic            presc_clr;
  tlc_state_t      state, state_nxt;
  logic [6:0]      phase_cnt, cnt_nxt;
  logic [1:0][6:0] cnt_v;   // [1]=NS, [0]=EW
  logic [1:0][7:0] bcd;

  function automatic logic [6:0] dur(input tlc_state_t s);
    return (s == NS_GREEN || s == EW_GREEN) ? G7 : Y7;
  endfunction

`ifdef TLC_NIGHT_MODE_EN
  logic blink, blink_nxt;
`else
  logic unused_night;
  assign unused_night = night;
`endif

  // Prescaler and tick register freeze together with en, so a paused
  // second resumes exactly where it stopped.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      tick_1s <= 1'b0;
    end else if (presc_clr) begin
      presc   <= '0;
      tick_1s <= 1'b0;
    end else if (en) begin
      tick_1s <= (presc == PW'(TICK_MAX));
      presc   <= (presc == PW'(TICK_MAX)) ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= NS_GREEN;
      phase_cnt <= G7;
`ifdef TLC_NIGHT_MODE_EN
      blink     <= 1'b1;
`endif
    end else begin
      state     <= state_nxt;
      phase_cnt <= cnt_nxt;
`ifdef TLC_NIGHT_MODE_EN
      blink     <= blink_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = phase_cnt;
    presc_clr = 1'b0;
`ifdef TLC_NIGHT_MODE_EN
    blink_nxt = blink;
`endif
    if (en && tick_1s && state != NIGHT_BLINK) begin
      if (phase_cnt > 7'd1) begin
        cnt_nxt = phase_cnt - 7'd1;
      end else begin
        state_nxt = tlc_next(state);
        cnt_nxt   = dur(tlc_next(state));
      end
    end
`ifdef TLC_NIGHT_MODE_EN
    // Night handling overrides the day step taken above.
    if (en) begin
      if (state == NIGHT_BLINK) begin
        if (!night) begin
          state_nxt = NS_GREEN;
          cnt_nxt   = G7;
          presc_clr = 1'b1;
        end else if (tick_1s) begin
          blink_nxt = ~blink;
        end
      end else if (night) begin
        state_nxt = NIGHT_BLINK;
        blink_nxt = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    light_ns = LAMP_R;
    light_ew = LAMP_R;
    cnt_v[1] = phase_cnt;
    cnt_v[0] = phase_cnt;
    case (state)
      NS_GREEN: begin
        light_ns = LAMP_G;
        cnt_v[0] = phase_cnt + Y7;
      end
      NS_YELLOW: light_ns = LAMP_Y;
      EW_GREEN: begin
        light_ew = LAMP_G;
        cnt_v[1] = phase_cnt + Y7;
      end
      EW_YELLOW: light_ew = LAMP_Y;
`ifdef TLC_NIGHT_MODE_EN
      NIGHT_BLINK: begin
        light_ns = blink ? LAMP_Y : LAMP_OFF;
        light_ew = blink ? LAMP_Y : LAMP_OFF;
      end
`endif
      default: ;
    endcase
  end

  for (genvar i = 0; i < 2; i++) begin : g_bcd
    bin2bcd_2d u_bcd (
      .bin(cnt_v[i]),
      .bcd(bcd[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)
      disp_data <= 16'h0000;
`ifdef TLC_NIGHT_MODE_EN
    else if (state == NIGHT_BLINK)
      disp_data <= {4{BCD_BLANK}};
`endif
    else
      disp_data <= {bcd[1], bcd[0]};
  end

endmodule
